// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - access size codes carried on ex_size
//   - FSM state encoding used by mem_stage_lsu
//   - byte-enable patterns used by lsu_lane_align
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_NONE    = 4'b0000;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit.
//   Request side (driven from the EX-stage inputs):
//     size, addr_lo  -> misaligned, be
//     wdata          -> wdata_rep (store data replicated into every lane)
//   Response side (driven from the lane info captured at request time):
//     rdata, ld_lane, ld_size, ld_unsigned -> ld_ext (extracted, extended)
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  logic [31:0] rdata,
    input  logic [1:0]  ld_lane,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    output logic [31:0] ld_ext
);

    logic [31:0] rshift;

    always_comb begin
        misaligned = 1'b0;
        be         = BE_NONE;
        wdata_rep  = wdata;
        case (size)
            SZ_BYTE: begin
                be        = BE_BYTE0 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_rep  = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                misaligned = |addr_lo;
                be         = BE_WORD;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend.
    assign rshift = rdata >> {ld_lane, 3'b000};

    always_comb begin
        ld_ext = rdata;
        case (ld_size)
            SZ_BYTE: ld_ext = ld_unsigned ? {24'h0, rshift[7:0]}
                                          : {{24{rshift[7]}}, rshift[7:0]};
            SZ_HALF: ld_ext = ld_unsigned ? {16'h0, rshift[15:0]}
                                          : {{16{rshift[15]}}, rshift[15:0]};
            default: ld_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: initiator side of the data-memory req/ack bus.
//   EX side : ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_unsigned,
//             ex_addr, ex_wdata (held stable by stall while a request is open)
//   Pipeline: stall (combinational), ld_valid/ld_data (to WB),
//             addr_err (misaligned/illegal size), bus_err (timeout abort)
//   Memory  : dm_req/dm_we/dm_addr/dm_be/dm_wdata (registered), dm_ack, dm_rdata
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no request open; EX inputs sampled, request issued or rejected
//   ST_WAIT | request open; waiting for dm_ack or the timeout
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        addr_err,
    output logic        bus_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             access;
    logic             timeout_hit;
    logic             issue, reject, done_ack, done_to;

    logic             misaligned;
    logic [3:0]       be;
    logic [31:0]      wdata_rep;
    logic [31:0]      ld_ext;

    // Lane/extension info for the open load, captured when it is issued.
    logic [1:0]       ld_lane;
    logic [1:0]       ld_size;
    logic             ld_unsigned;

    assign access      = ex_valid & (ex_mem_read | ex_mem_write);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST) && !dm_ack;

    lsu_lane_align u_align (
        .size        (ex_size),
        .addr_lo     (ex_addr[1:0]),
        .wdata       (ex_wdata),
        .misaligned  (misaligned),
        .be          (be),
        .wdata_rep   (wdata_rep),
        .rdata       (dm_rdata),
        .ld_lane     (ld_lane),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .ld_ext      (ld_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        issue      = 1'b0;
        reject     = 1'b0;
        done_ack   = 1'b0;
        done_to    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        reject = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        issue      = 1'b1;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Ack is tested first so it wins over a same-cycle timeout.
                if (dm_ack) begin
                    done_ack   = 1'b1;
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    done_to    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= 32'h0;
            dm_be       <= 4'h0;
            dm_wdata    <= 32'h0;
            ld_valid    <= 1'b0;
            ld_data     <= 32'h0;
            addr_err    <= 1'b0;
            bus_err     <= 1'b0;
            cnt         <= '0;
            ld_lane     <= 2'b00;
            ld_size     <= 2'b00;
            ld_unsigned <= 1'b0;
        end else begin
            ld_valid <= 1'b0;
            addr_err <= reject;
            bus_err  <= done_to;

            if (issue) begin
                dm_req      <= 1'b1;
                dm_we       <= ex_mem_write;
                dm_addr     <= {ex_addr[31:2], 2'b00};
                dm_be       <= be;
                dm_wdata    <= wdata_rep;
                ld_lane     <= ex_addr[1:0];
                ld_size     <= ex_size;
                ld_unsigned <= ex_unsigned;
                cnt         <= '0;
            end

            if (done_ack) begin
                dm_req <= 1'b0;
                if (!dm_we) begin
                    ld_valid <= 1'b1;
                    ld_data  <= ld_ext;
                end
            end

            if (done_to) dm_req <= 1'b0;

            if (state == ST_WAIT && !dm_ack && !timeout_hit) cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic        stall, ld_valid, addr_err, bus_err;
    logic [31:0] ld_data;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_ld = 32'h0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
        .addr_err(addr_err), .bus_err(bus_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // ---- reference model: byte-level arithmetic ----
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit m_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] r;
        int lo;
        r  = 4'b0000;
        lo = int'(a % 4);
        for (int k = 0; k < nbytes(sz); k++) r[lo + k] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = nbytes(sz);
        for (int j = 0; j < 4; j++) r[8*j +: 8] = wd[8*(j % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input bit uns,
                                           input logic [31:0] a, input logic [31:0] rd);
        longint v;
        int n, lo;
        n  = nbytes(sz);
        lo = int'(a % 4);
        v  = 0;
        for (int k = 0; k < n; k++) v = v + (longint'(rd[8*(lo + k) +: 8]) << (8*k));
        if (!uns && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    // Entered and left just after a rising edge. ack_at = WAIT cycle (1-based)
    // in which the memory acks; values above TO mean the memory never answers.
    task automatic do_access(input bit wr, input logic [1:0] sz, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int ack_at, input logic [31:0] rd);
        int  stalls;
        bit  acked;
        stalls       = 0;
        ex_valid     = 1'b1;
        ex_mem_write = wr;
        ex_mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        ex_size      = sz;
        ex_unsigned  = uns;
        ex_addr      = addr;
        ex_wdata     = wd;
        #1;
        if (m_err(sz, addr)) begin
            chk("err_stall", {31'h0, stall}, 32'h0);
            @(posedge clk); #1;
            ex_valid = 1'b0;
            chk("err_addr_err", {31'h0, addr_err}, 32'h1);
            chk("err_no_req", {31'h0, dm_req}, 32'h0);
            chk("err_no_ld", {31'h0, ld_valid}, 32'h0);
            @(posedge clk); #1;
            chk("err_pulse_end", {31'h0, addr_err}, 32'h0);
            return;
        end
        if (stall) stalls++;
        chk("issue_stall", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        chk("req_high", {31'h0, dm_req}, 32'h1);
        chk("req_we", {31'h0, dm_we}, {31'h0, wr});
        chk("req_addr", dm_addr, addr & 32'hFFFF_FFFC);
        chk("req_be", {28'h0, dm_be}, {28'h0, m_be(sz, addr)});
        if (wr) chk("req_wdata", dm_wdata, m_wdata(sz, wd));
        for (int i = 1; i <= TO; i++) begin
            dm_ack   = (i == ack_at);
            dm_rdata = rd;
            #1;
            if (stall) stalls++;
            chk("wait_req_held", {31'h0, dm_req}, 32'h1);
            @(posedge clk); #1;
            dm_ack   = 1'b0;
            dm_rdata = $urandom;
            if (i == ack_at || i == TO) break;
        end
        ex_valid = 1'b0;
        acked    = (ack_at <= TO);
        chk("stall_cycles", stalls, (ack_at < TO) ? ack_at : TO);
        chk("req_dropped", {31'h0, dm_req}, 32'h0);
        chk("bus_err", {31'h0, bus_err}, {31'h0, !acked});
        chk("ld_valid", {31'h0, ld_valid}, {31'h0, acked && !wr});
        if (acked && !wr) last_ld = m_load(sz, uns, addr, rd);
        chk("ld_data", ld_data, last_ld);
        @(posedge clk); #1;
        chk("ld_valid_pulse", {31'h0, ld_valid}, 32'h0);
        chk("bus_err_pulse", {31'h0, bus_err}, 32'h0);
        chk("ld_data_keep", ld_data, last_ld);
    endtask

    initial begin
        reset = 1'b1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_size = 2'b00; ex_unsigned = 1'b0; ex_addr = 32'h0; ex_wdata = 32'h0;
        dm_ack = 1'b0; dm_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dm_req", {31'h0, dm_req}, 32'h0);
        chk("rst_dm_we", {31'h0, dm_we}, 32'h0);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_be", {28'h0, dm_be}, 32'h0);
        chk("rst_dm_wdata", dm_wdata, 32'h0);
        chk("rst_ld_valid", {31'h0, ld_valid}, 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // directed
        do_access(1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 2, 32'h0);
        do_access(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00A5, 1, 32'h0);
        do_access(1'b0, 2'b00, 1'b0, 32'h0000_0022, 32'h0, 1, 32'h0080_0000);
        chk("lb_value", last_ld, 32'hFFFF_FF80);
        do_access(1'b0, 2'b00, 1'b1, 32'h0000_0022, 32'h0, 1, 32'h0080_0000);
        chk("lbu_value", last_ld, 32'h0000_0080);
        do_access(1'b0, 2'b01, 1'b0, 32'h0000_0031, 32'h0, 1, 32'h0);
        do_access(1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0);
        do_access(1'b0, 2'b10, 1'b0, 32'h0000_0050, 32'h0, TO + 1, 32'h1234_5678);
        do_access(1'b0, 2'b10, 1'b1, 32'h0000_0050, 32'h0, TO, 32'h8765_4321);
        do_access(1'b0, 2'b01, 1'b0, 32'h0000_0062, 32'h0, 3, 32'h8001_7FFF);

        // randomized
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a  = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(sz)) - 32'h1);
            do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                      $urandom, $urandom_range(1, TO + 1), $urandom);
        end

        // reset while a request is open
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_size = 2'b10; ex_unsigned = 1'b0; ex_addr = 32'h0000_0040;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("rw_req_open", {31'h0, dm_req}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rw_req_async_clear", {31'h0, dm_req}, 32'h0);
        chk("rw_stall", {31'h0, stall}, 32'h0);
        last_ld = 32'h0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk("stray_ack_no_ld", {31'h0, ld_valid}, 32'h0);
        chk("stray_ack_no_req", {31'h0, dm_req}, 32'h0);
        @(posedge clk); #1;
        chk("stray_ack_no_ld2", {31'h0, ld_valid}, 32'h0);
        chk("stray_ack_ld_data", ld_data, last_ld);

        // unit still works after reset
        do_access(1'b0, 2'b01, 1'b1, 32'h0000_0082, 32'h0, 1, 32'hBEEF_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
